// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit: forward selects,
// memory-wait FSM states and the bundle of stall/flush controls.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_ctrl_t;

endpackage

// File: rtl/hazard_mem_fsm.sv
// Data-memory wait tracker: freezes the pipe while a load/store in M is unacknowledged,
// with a bounded wait (MEM_TIMEOUT stalled cycles) and a sticky timeout error flag.
module hazard_mem_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_req_i,
  input  logic mem_ack_i,
  output logic mem_stall_o,
  output logic mem_err_o
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // cnt_q holds the number of stalled cycles already spent on the current access
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    mem_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_req_i && !mem_ack_i) begin
          mem_stall_o = 1'b1;
          state_d     = WAIT;
          cnt_d       = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!mem_req_i || mem_ack_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          mem_stall_o = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign mem_err_o = err_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use bubble, branch flush and
// data-memory wait stalls. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REGISTER_ADDRESS_WIDTH = 5,
  parameter int unsigned MEM_TIMEOUT            = 16,
  parameter int unsigned COUNTER_WIDTH          = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
  input  logic [1:0]                        ResultSrcE_i,
  input  logic                              PCSrcE_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
  input  logic                              RegWriteM_i,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
  input  logic                              RegWriteW_i,
  input  logic                              MemReqM_i,
  input  logic                              MemAckM_i,
  output logic [1:0]                        ForwardAE_o,
  output logic [1:0]                        ForwardBE_o,
  output logic                              StallF_o,
  output logic                              StallD_o,
  output logic                              StallE_o,
  output logic                              StallM_o,
  output logic                              FlushD_o,
  output logic                              FlushE_o,
  output logic                              FlushW_o,
  output logic                              MemErr_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [COUNTER_WIDTH-1:0]          StallCount_o,
  output logic [COUNTER_WIDTH-1:0]          FlushCount_o
`endif
);

  fwd_sel_e     fwd_a_c, fwd_b_c;
  logic         lw_stall_c;
  logic         mem_stall_c;
  hazard_ctrl_t ctrl_c;

  // M-stage result has priority over W-stage; x0 is never forwarded
  always_comb begin
    fwd_a_c = FWD_REG;
    fwd_b_c = FWD_REG;
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs1E_i)) begin
      fwd_a_c = FWD_M;
    end else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs1E_i)) begin
      fwd_a_c = FWD_W;
    end
    if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs2E_i)) begin
      fwd_b_c = FWD_M;
    end else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs2E_i)) begin
      fwd_b_c = FWD_W;
    end
  end

  assign ForwardAE_o = fwd_a_c;
  assign ForwardBE_o = fwd_b_c;

  assign lw_stall_c = (ResultSrcE_i == RESULT_SRC_LOAD) && (RdE_i != '0) &&
                      ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

  hazard_mem_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_req_i   (MemReqM_i),
    .mem_ack_i   (MemAckM_i),
    .mem_stall_o (mem_stall_c),
    .mem_err_o   (MemErr_o)
  );

  // A frozen pipe defers branch and load-use actions; a taken branch beats load-use
  always_comb begin
    ctrl_c = '0;
    if (mem_stall_c) begin
      ctrl_c.stall_f = 1'b1;
      ctrl_c.stall_d = 1'b1;
      ctrl_c.stall_e = 1'b1;
      ctrl_c.stall_m = 1'b1;
      ctrl_c.flush_w = 1'b1;
    end else if (PCSrcE_i) begin
      ctrl_c.flush_d = 1'b1;
      ctrl_c.flush_e = 1'b1;
    end else if (lw_stall_c) begin
      ctrl_c.stall_f = 1'b1;
      ctrl_c.stall_d = 1'b1;
      ctrl_c.flush_e = 1'b1;
    end
  end

  assign StallF_o = ctrl_c.stall_f;
  assign StallD_o = ctrl_c.stall_d;
  assign StallE_o = ctrl_c.stall_e;
  assign StallM_o = ctrl_c.stall_m;
  assign FlushD_o = ctrl_c.flush_d;
  assign FlushE_o = ctrl_c.flush_e;
  assign FlushW_o = ctrl_c.flush_w;

`ifdef HAZARD_PERF_CNT_EN
  logic [COUNTER_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

  // Free-running event counters; wrap naturally at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ctrl_c.stall_f) stall_cnt_q <= stall_cnt_q + COUNTER_WIDTH'(1);
      if (ctrl_c.flush_d) flush_cnt_q <= flush_cnt_q + COUNTER_WIDTH'(1);
    end
  end

  assign StallCount_o = stall_cnt_q;
  assign FlushCount_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a driver pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares against the DUT.
module tb_hazard_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_i = 1'b1;
  logic [AW-1:0] Rs1D_i = '0, Rs2D_i = '0, Rs1E_i = '0, Rs2E_i = '0, RdE_i = '0;
  logic [AW-1:0] RdM_i = '0, RdW_i = '0;
  logic [1:0]    ResultSrcE_i = '0;
  logic          PCSrcE_i = 1'b0, RegWriteM_i = 1'b0, RegWriteW_i = 1'b0;
  logic          MemReqM_i = 1'b0, MemAckM_i = 1'b0;
  logic [1:0]    ForwardAE_o, ForwardBE_o;
  logic          StallF_o, StallD_o, StallE_o, StallM_o;
  logic          FlushD_o, FlushE_o, FlushW_o, MemErr_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] StallCount_o, FlushCount_o;
`endif

  hazard_unit #(
    .REGISTER_ADDRESS_WIDTH (AW),
    .MEM_TIMEOUT            (TO),
    .COUNTER_WIDTH          (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .Rs1D_i       (Rs1D_i),
    .Rs2D_i       (Rs2D_i),
    .Rs1E_i       (Rs1E_i),
    .Rs2E_i       (Rs2E_i),
    .RdE_i        (RdE_i),
    .ResultSrcE_i (ResultSrcE_i),
    .PCSrcE_i     (PCSrcE_i),
    .RdM_i        (RdM_i),
    .RegWriteM_i  (RegWriteM_i),
    .RdW_i        (RdW_i),
    .RegWriteW_i  (RegWriteW_i),
    .MemReqM_i    (MemReqM_i),
    .MemAckM_i    (MemAckM_i),
    .ForwardAE_o  (ForwardAE_o),
    .ForwardBE_o  (ForwardBE_o),
    .StallF_o     (StallF_o),
    .StallD_o     (StallD_o),
    .StallE_o     (StallE_o),
    .StallM_o     (StallM_o),
    .FlushD_o     (FlushD_o),
    .FlushE_o     (FlushE_o),
    .FlushW_o     (FlushW_o),
    .MemErr_o     (MemErr_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount_o (StallCount_o),
    .FlushCount_o (FlushCount_o)
`endif
  );

  typedef struct {
    int fa, fb, sf, sd, se, sm, fd, fe, fw, err, sc, fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: stalled cycles spent on the outstanding access, sticky error, event counts
  int   waited = 0;
  bit   err_m  = 1'b0;
  int   scnt   = 0;
  int   fcnt   = 0;

  function automatic int fwd_ref(input int rs);
    if (RegWriteM_i && RdM_i != 0 && int'(RdM_i) == rs) return 2;
    if (RegWriteW_i && RdW_i != 0 && int'(RdW_i) == rs) return 1;
    return 0;
  endfunction

  task automatic step();
    exp_t e;
    bit   mem_stall, lw;
    int   mask;
    mask      = (1 << CW) - 1;
    mem_stall = MemReqM_i && !MemAckM_i && (waited < int'(TO));
    lw        = (ResultSrcE_i == 2'b01) && (RdE_i != 0) && (RdE_i == Rs1D_i || RdE_i == Rs2D_i);
    e.fa  = fwd_ref(int'(Rs1E_i));
    e.fb  = fwd_ref(int'(Rs2E_i));
    e.sf  = int'(mem_stall || (lw && !PCSrcE_i));
    e.sd  = e.sf;
    e.se  = int'(mem_stall);
    e.sm  = int'(mem_stall);
    e.fw  = int'(mem_stall);
    e.fd  = int'(!mem_stall && PCSrcE_i);
    e.fe  = int'(!mem_stall && (PCSrcE_i || lw));
    e.err = int'(err_m);
    e.sc  = scnt;
    e.fc  = fcnt;
    sb_q.push_back(e);
    if (rst_i) begin
      waited = 0;
      err_m  = 1'b0;
      scnt   = 0;
      fcnt   = 0;
    end else begin
      if (e.sf != 0) scnt = (scnt + 1) & mask;
      if (e.fd != 0) fcnt = (fcnt + 1) & mask;
      if (mem_stall) begin
        waited++;
      end else begin
        if (MemReqM_i && !MemAckM_i) err_m = 1'b1;
        waited = 0;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_idle();
    rst_i = 1'b0; Rs1D_i = '0; Rs2D_i = '0; Rs1E_i = '0; Rs2E_i = '0; RdE_i = '0;
    RdM_i = '0; RdW_i = '0; ResultSrcE_i = '0; PCSrcE_i = 1'b0;
    RegWriteM_i = 1'b0; RegWriteW_i = 1'b0; MemReqM_i = 1'b0; MemAckM_i = 1'b0;
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s t=%0t act=%0d exp=%0d", nm, $time, act, exp_v);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("ForwardAE", int'(ForwardAE_o), e.fa);
        chk("ForwardBE", int'(ForwardBE_o), e.fb);
        chk("StallF",    int'(StallF_o),    e.sf);
        chk("StallD",    int'(StallD_o),    e.sd);
        chk("StallE",    int'(StallE_o),    e.se);
        chk("StallM",    int'(StallM_o),    e.sm);
        chk("FlushD",    int'(FlushD_o),    e.fd);
        chk("FlushE",    int'(FlushE_o),    e.fe);
        chk("FlushW",    int'(FlushW_o),    e.fw);
        chk("MemErr",    int'(MemErr_o),    e.err);
`ifdef HAZARD_PERF_CNT_EN
        chk("StallCount", int'(StallCount_o), e.sc);
        chk("FlushCount", int'(FlushCount_o), e.fc);
`endif
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    set_idle();
    step(); step();

    // forwarding priority and x0 exclusion
    RdM_i = 5; RdW_i = 5; RegWriteM_i = 1; RegWriteW_i = 1; Rs1E_i = 5; Rs2E_i = 5; step();
    RegWriteM_i = 0; step();
    RdM_i = 0; RdW_i = 0; RegWriteM_i = 1; Rs1E_i = 0; Rs2E_i = 0; step();
    set_idle();

    // load-use bubble, then with taken branch
    ResultSrcE_i = 2'b01; RdE_i = 3; Rs2D_i = 3; step();
    set_idle(); step();
    ResultSrcE_i = 2'b01; RdE_i = 3; Rs2D_i = 3; PCSrcE_i = 1; step();
    set_idle(); step();

    // three wait cycles then ack; then same-cycle ack
    MemReqM_i = 1; repeat (3) step();
    MemAckM_i = 1; step();
    set_idle(); step();
    MemReqM_i = 1; MemAckM_i = 1; step();
    set_idle(); step();

    // timeout with sticky error, cleared only by reset
    MemReqM_i = 1; repeat (5) step();
    set_idle(); repeat (3) step();
    rst_i = 1; step();
    set_idle(); step();

    // reset pulsed in the second WAIT cycle
    MemReqM_i = 1; step(); step();
    rst_i = 1; step();
    set_idle(); step(); step();

    // two load-use stalls plus three wait cycles
    ResultSrcE_i = 2'b01; RdE_i = 7; Rs1D_i = 7; step();
    set_idle(); step();
    ResultSrcE_i = 2'b01; RdE_i = 2; Rs2D_i = 2; step();
    set_idle(); step();
    MemReqM_i = 1; repeat (3) step();
    MemAckM_i = 1; step();
    set_idle(); step();

    // randomized traffic over a small register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      Rs1D_i = AW'($urandom_range(0, 3)); Rs2D_i = AW'($urandom_range(0, 3));
      Rs1E_i = AW'($urandom_range(0, 3)); Rs2E_i = AW'($urandom_range(0, 3));
      RdE_i  = AW'($urandom_range(0, 3)); RdM_i  = AW'($urandom_range(0, 3));
      RdW_i  = AW'($urandom_range(0, 3));
      ResultSrcE_i = 2'($urandom_range(0, 3));
      PCSrcE_i     = ($urandom_range(0, 3) == 0);
      RegWriteM_i  = ($urandom_range(0, 1) == 1);
      RegWriteW_i  = ($urandom_range(0, 1) == 1);
      MemReqM_i    = ($urandom_range(0, 3) != 0);
      MemAckM_i    = ($urandom_range(0, 3) == 0);
      rst_i        = ($urandom_range(0, 63) == 0);
      step();
    end
    set_idle(); step();

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk_i);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REGISTER_ADDRESS_WIDTH, default 5: register index width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: maximum data-memory wait cycles.
REQ-003 SHALL have parameter COUNTER_WIDTH, default 32: performance counter width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i input 1 (rising edge) and rst_i input 1.
REQ-005 SHALL have these decode-stage source indices: Rs1D_i input RAW, Rs1 index; Rs2D_i input RAW, Rs2 index.
REQ-006 SHALL have these execute-stage inputs: Rs1E_i and Rs2E_i input RAW, sources; RdE_i input RAW, destination; ResultSrcE_i input 2, where 2'b01 means load; PCSrcE_i input 1, branch/jump taken.
REQ-007 SHALL have these memory and writeback inputs: RdM_i input RAW; RegWriteM_i input 1; RdW_i input RAW; RegWriteW_i input 1.
REQ-008 SHALL have the memory handshake: MemReqM_i input 1, load/store in M; MemAckM_i input 1, data memory complete.
REQ-009 SHALL have forwarding outputs: ForwardAE_o output 2, ALU operand A select; ForwardBE_o output 2, operand B select.
REQ-010 SHALL have control outputs, each output 1: StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o.
REQ-011 SHALL have MemErr_o output 1: sticky memory timeout flag.

Function
REQ-012 SHALL set ForwardAE_o to 2'b10 when RegWriteM_i, RdM_i!=0 and RdM_i==Rs1E_i; else 2'b01 when RegWriteW_i, RdW_i!=0 and RdW_i==Rs1E_i; else 2'b00. ForwardBE_o follows the same rule using Rs2E_i.
REQ-013 SHALL compute lwStall = (ResultSrcE_i==2'b01) & RdE_i!=0 & (RdE_i==Rs1D_i | RdE_i==Rs2D_i), combinationally.
REQ-014 SHALL, when lwStall & !PCSrcE_i, assert StallF_o, StallD_o and FlushE_o for that cycle only; this inserts one bubble.
REQ-015 SHALL, when PCSrcE_i, assert FlushD_o and FlushE_o and suppress the lwStall stalls; taken branch wins.
REQ-016 SHALL contain memory FSM states IDLE and WAIT.
REQ-017 SHALL move from IDLE to WAIT on MemReqM_i & !MemAckM_i. MemReqM_i & MemAckM_i in the same cycle causes no stall and stays in IDLE.
REQ-018 SHALL, combinationally while (IDLE & MemReqM_i & !MemAckM_i) or (WAIT & !MemAckM_i), assert StallF_o, StallD_o, StallE_o, StallM_o and FlushW_o. During this condition it SHALL deassert FlushD_o and FlushE_o, so branch and load-use actions are deferred while the pipe is frozen.
REQ-019 SHALL, in WAIT with MemAckM_i, drop all memory stalls that same cycle and return to IDLE on the next edge.
REQ-020 SHALL count wait cycles in WAIT. When MEM_TIMEOUT cycles elapse without MemAckM_i, it SHALL set MemErr_o, release the stalls in that cycle and return to IDLE.
REQ-021 SHALL keep MemErr_o set until rst_i.
REQ-022 SHALL treat MemReqM_i deasserting in WAIT as an abort: return to IDLE and release stalls.

Reset
REQ-023 SHALL, on rst_i at the rising edge, force the FSM to IDLE, clear the wait counter, clear MemErr_o and clear the performance counters.
REQ-024 SHALL, when rst_i is asserted mid-WAIT, deassert all stall and flush outputs from the next cycle; the combinational forwarding outputs are unaffected.

Configuration
REQ-025 SHALL, with HAZARD_PERF_CNT_EN defined, add outputs StallCount_o and FlushCount_o, each COUNTER_WIDTH wide.
REQ-026 SHALL increment StallCount_o on every cycle StallF_o=1 and FlushCount_o on every cycle FlushD_o=1. Both counters wrap from all-ones to zero.
REQ-027 SHALL, without HAZARD_PERF_CNT_EN, omit these ports and all counter logic.

Structure
REQ-028 SHALL place in shared package hazard_pkg: the forward-select enum (FWD_REG=00, FWD_W=01, FWD_M=10), the memory FSM state enum, and the constant RESULT_SRC_LOAD=2'b01.
REQ-029 SHALL implement the memory FSM and timeout counter as sub-module hazard_mem_fsm. Forwarding and lwStall logic stay in the top module.

Verification
REQ-030 SHALL cover forwarding priority: RdM_i=RdW_i=5, both RegWrite=1, Rs1E_i=5 -> ForwardAE_o=2'b10. Rd=0 with Rs1E_i=0 -> 2'b00.
REQ-031 SHALL cover load-use: ResultSrcE_i=01, RdE_i=3, Rs2D_i=3, PCSrcE_i=0 -> StallF_o/StallD_o/FlushE_o high exactly one cycle. Adding PCSrcE_i=1 -> FlushD_o=FlushE_o=1 and StallF_o=0.
REQ-032 SHALL cover memory wait: MemReqM_i=1 with MemAckM_i low for 3 cycles -> Stall*_o and FlushW_o high for exactly 3 cycles, low in the ack cycle. Same-cycle ack -> no stall.
REQ-033 SHALL cover timeout: MEM_TIMEOUT=4 and no ack -> stalls released after 4 cycles, MemErr_o=1 held until rst_i.
REQ-034 SHALL cover reset mid-WAIT: rst_i pulsed in cycle 2 of WAIT -> FSM IDLE and stalls low next cycle.
REQ-035 SHALL cover counters with HAZARD_PERF_CNT_EN: 2 load-use stalls plus 3 wait cycles -> StallCount_o=5. With COUNTER_WIDTH=4, preload to 15 and stall once -> wraps to 0.
